// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin, lockable arbiter sharing one ALU between two requesters
// Owns the carry/overflow flags; results are registered one cycle after accept.
module alu_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][WORD_WIDTH-1:0] req_a,
  input  logic [1:0][WORD_WIDTH-1:0] req_b,
  input  logic [1:0]                 req_ic,
  input  logic [1:0][3:0]            req_opcode,
  input  logic [1:0]                 req_store_carry,
  input  logic [1:0]                 req_store_overflow,
  input  logic [1:0]                 req_lock,
  output logic [WORD_WIDTH-1:0]      alu_a,
  output logic [WORD_WIDTH-1:0]      alu_b,
  output logic                       alu_ic,
  output logic [3:0]                 alu_opcode,
  input  logic [WORD_WIDTH-1:0]      alu_out,
  input  logic                       alu_oc,
  input  logic                       alu_oflow,
  output logic [1:0]                 rsp_valid,
  output logic [WORD_WIDTH-1:0]      rsp_result,
  output logic                       carry,
  output logic                       overflow
);

  localparam logic [1:0] ST_OPEN  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam int         CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  carry_q, carry_d;
  logic                  overflow_q, overflow_d;

  logic locked, owner, timeout, accept, g;

  always_comb begin
    locked  = (state_q != ST_OPEN);
    owner   = (state_q == ST_LOCK1);
    timeout = locked && (lock_cnt_q == LOCK_MAX);
    accept  = 1'b0;
    g       = 1'b0;
    // Once the lock has timed out the non-owner is preferred on a tie.
    if (locked && !timeout) begin
      accept = req_valid[owner];
      g      = owner;
    end else if (req_valid == 2'b11) begin
      accept = 1'b1;
      g      = timeout ? ~owner : ~last_grant_q;
    end else if (req_valid != 2'b00) begin
      accept = 1'b1;
      g      = req_valid[1];
    end
  end

  always_comb begin
    req_ready  = {accept && g, accept && !g};
    alu_a      = '0;
    alu_b      = '0;
    alu_ic     = 1'b0;
    alu_opcode = OP_NOP;
    if (accept) begin
      alu_a      = req_a[g];
      alu_b      = req_b[g];
      alu_ic     = req_ic[g];
      alu_opcode = req_opcode[g];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    rsp_valid_d  = 2'b00;
    rsp_result_d = rsp_result_q;
    carry_d      = carry_q;
    overflow_d   = overflow_q;
    if (accept) begin
      last_grant_d = g;
      rsp_valid_d  = req_ready;
      rsp_result_d = alu_out;
      if (req_store_carry[g])    carry_d    = alu_oc;
      if (req_store_overflow[g]) overflow_d = alu_oflow;
      if (!req_lock[g]) begin
        state_d    = ST_OPEN;
        lock_cnt_d = '0;
      end else if (locked && !timeout) begin
        if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
        state_d    = g ? ST_LOCK1 : ST_LOCK0;
        lock_cnt_d = '0;
      end
    end else if (timeout) begin
      state_d    = ST_OPEN;
      lock_cnt_d = '0;
    end else if (locked && lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OPEN;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      carry_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      carry_q      <= carry_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign carry      = carry_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an ALU stub and arbitration model
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int ML = 8;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_ADDC = 4'h2, OP_SUB = 4'h3,
                         OP_SUBC = 4'h4, OP_AND = 4'h5, OP_OR = 4'h6, OP_XOR = 4'h7;

  typedef struct {
    logic v; logic [W-1:0] a; logic [W-1:0] b; logic ic;
    logic [3:0] op; logic sc; logic so; logic lk;
  } req_t;
  typedef struct { int port; logic [W-1:0] res; logic c; logic o; } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] req_valid, req_ready, req_ic, req_store_carry, req_store_overflow, req_lock;
  logic [1:0][W-1:0] req_a, req_b;
  logic [1:0][3:0] req_opcode;
  logic [W-1:0] alu_a, alu_b, alu_out, rsp_result;
  logic alu_ic, alu_oc, alu_oflow, carry, overflow;
  logic [3:0] alu_opcode;
  logic [1:0] rsp_valid;

  alu_arbiter #(.WORD_WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ic(req_ic), .req_opcode(req_opcode),
    .req_store_carry(req_store_carry), .req_store_overflow(req_store_overflow),
    .req_lock(req_lock), .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic),
    .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_oc(alu_oc), .alu_oflow(alu_oflow),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Returns {overflow, carry_out, result}
  function automatic logic [W+1:0] alu_fn(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ic);
    logic [W:0] s;
    logic ovf;
    s = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      OP_ADDC: s = {1'b0, a} + {1'b0, b} + (W+1)'(ic);
      OP_SUB:  s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      OP_SUBC: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(ic);
      OP_AND:  s = {1'b0, a & b};
      OP_OR:   s = {1'b0, a | b};
      OP_XOR:  s = {1'b0, a ^ b};
      default: s = '0;
    endcase
    if (op == OP_ADD || op == OP_ADDC) ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    if (op == OP_SUB || op == OP_SUBC) ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s};
  endfunction

  always_comb {alu_oflow, alu_oc, alu_out} = alu_fn(alu_opcode, alu_a, alu_b, alu_ic);

  req_t rq[2];
  rsp_t sbq[$];
  int n_vec = 0, n_fail = 0;
  int m_owner = -1, m_age = 0, m_last = 1, last_g = -1;
  logic m_c = 1'b0, m_o = 1'b0;
  logic [W-1:0] mon_res = '0;
  logic mon_c = 1'b0, mon_o = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(logic v, logic [W-1:0] a, logic [W-1:0] b, logic ic,
                              logic [3:0] op, logic sc, logic so, logic lk);
    req_t r;
    r.v = v; r.a = a; r.b = b; r.ic = ic; r.op = op; r.sc = sc; r.so = so; r.lk = lk;
    return r;
  endfunction

  task automatic apply();
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = rq[p].v; req_a[p] = rq[p].a; req_b[p] = rq[p].b;
      req_ic[p] = rq[p].ic; req_opcode[p] = rq[p].op; req_store_carry[p] = rq[p].sc;
      req_store_overflow[p] = rq[p].so; req_lock[p] = rq[p].lk;
    end
  endtask

  function automatic bit lock_expired();
    return (m_owner >= 0) && (m_age >= ML);
  endfunction

  // Who should win this cycle, -1 for nobody
  function automatic int pick(logic [1:0] v);
    if (m_owner >= 0 && !lock_expired()) return v[m_owner] ? m_owner : -1;
    if (v == 2'b11) return lock_expired() ? 1 - m_owner : 1 - m_last;
    if (v == 2'b00) return -1;
    return v[1] ? 1 : 0;
  endfunction

  task automatic step();
    int g;
    bit expired;
    logic [W+1:0] r;
    logic [1:0] er;
    rsp_t it;
    @(posedge clk);
    #3;
    apply();
    #1;
    expired = lock_expired();
    g = pick({rq[1].v, rq[0].v});
    er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    chk("req_ready", req_ready, er);
    if (g >= 0) begin
      chk("alu_a", alu_a, rq[g].a);
      chk("alu_b", alu_b, rq[g].b);
      chk("alu_ic", alu_ic, rq[g].ic);
      chk("alu_opcode", alu_opcode, rq[g].op);
      r = alu_fn(rq[g].op, rq[g].a, rq[g].b, rq[g].ic);
      if (rq[g].sc) m_c = r[W];
      if (rq[g].so) m_o = r[W+1];
      it.port = g; it.res = r[W-1:0]; it.c = m_c; it.o = m_o;
      sbq.push_back(it);
      if (!rq[g].lk) begin
        m_owner = -1; m_age = 0;
      end else if (m_owner == g && !expired) begin
        m_age = (m_age < ML) ? m_age + 1 : ML;
      end else begin
        m_owner = g; m_age = 0;
      end
      m_last = g;
    end else begin
      chk("idle_opcode", alu_opcode, OP_NOP);
      chk("idle_ab", {alu_a, alu_b}, 64'd0);
      chk("idle_ic", alu_ic, 1'b0);
      if (m_owner >= 0) begin
        if (expired) begin m_owner = -1; m_age = 0; end
        else m_age = (m_age < ML) ? m_age + 1 : ML;
      end
    end
    last_g = g;
  endtask

  task automatic model_reset();
    sbq.delete();
    m_owner = -1; m_age = 0; m_last = 1; m_c = 1'b0; m_o = 1'b0;
    mon_res = '0; mon_c = 1'b0; mon_o = 1'b0;
  endtask

  task automatic rand_req(int p);
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 5))
      0: a = 32'hFFFF_FFFF;
      1: a = 32'h7FFF_FFFF;
      2: b = 32'h0000_0001;
      default: ;
    endcase
    rq[p] = mk($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
  endtask

  initial begin : monitor
    rsp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (rsp_valid != 2'b00) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 2'b00);
          end else begin
            it = sbq.pop_front();
            chk("rsp_valid", rsp_valid, (it.port == 0) ? 2'b01 : 2'b10);
            chk("rsp_result", rsp_result, it.res);
            chk("carry", carry, it.c);
            chk("overflow", overflow, it.o);
            mon_res = it.res; mon_c = it.c; mon_o = it.o;
          end
        end else begin
          if (sbq.size() != 0) begin
            it = sbq.pop_front();
            chk("missing_rsp", rsp_valid, (it.port == 0) ? 2'b01 : 2'b10);
            mon_res = it.res; mon_c = it.c; mon_o = it.o;
          end
          chk("hold_result", rsp_result, mon_res);
          chk("hold_carry", carry, mon_c);
          chk("hold_overflow", overflow, mon_o);
        end
      end
    end
  end

  initial begin : driver
    int n;
    bit found;
    rq[0] = mk(0, 0, 0, 0, OP_NOP, 0, 0, 0);
    rq[1] = rq[0];
    apply();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // Reset in the middle of traffic
    rq[0] = mk(1, 32'hFFFF_FFFF, 32'h1, 0, OP_ADD, 1, 0, 0);
    step();
    rq[0].v = 1'b0;
    rq[1] = mk(1, 32'd5, 32'd6, 0, OP_ADD, 0, 0, 0);
    step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rq[0].v = 1'b0; rq[1].v = 1'b0;
    apply();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    // First tie after reset, then alternating grants
    rq[0] = mk(1, $urandom, $urandom, 0, OP_ADD, 0, 0, 0);
    rq[1] = mk(1, $urandom, $urandom, 0, OP_ADD, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_grant_seq", last_g, i % 2);
      if (last_g >= 0) rq[last_g] = mk(1, $urandom, $urandom, 0, OP_ADD, 0, 0, 0);
    end

    // Locked ADD/ADDC chain with port 1 waiting
    rq[0] = mk(1, 32'hFFFF_FFFF, 32'h1, 0, OP_ADD, 1, 0, 1);
    rq[1] = mk(1, 32'h10, 32'h20, 0, OP_ADD, 0, 0, 0);
    step();
    chk("t3_first", last_g, 0);
    rq[0] = mk(1, 32'h0, 32'h0, m_c, OP_ADDC, 1, 0, 0);
    step();
    chk("t3_second", last_g, 0);
    rq[0].v = 1'b0;
    step();
    chk("t3_port1_after", last_g, 1);
    chk("t3_carry_end", carry, 1'b0);
    rq[1].v = 1'b0;

    // Flag store enables
    rq[0] = mk(1, 32'hFFFF_FFFF, 32'h1, 0, OP_ADD, 1, 0, 0);
    step();
    rq[0] = mk(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, OP_AND, 0, 0, 0);
    step();
    rq[0].v = 1'b0;
    step();
    chk("t5_carry_hold", carry, 1'b1);
    rq[0] = mk(1, 32'h7FFF_FFFF, 32'h1, 0, OP_ADD, 0, 1, 0);
    step();
    rq[0].v = 1'b0;
    step();
    chk("t5_overflow", overflow, 1'b1);
    step();
    chk("t6_idle_valid", rsp_valid, 2'b00);
    chk("t6_idle_result", rsp_result, 32'h8000_0000);
    chk("t6_idle_nop", alu_opcode, OP_NOP);

    // Lock timeout: idle owner loses the ALU after MAX_LOCK cycles
    rq[1] = mk(1, 32'h1, 32'h2, 0, OP_ADD, 0, 0, 1);
    step();
    chk("t4_lock_grant", last_g, 1);
    rq[1].v = 1'b0;
    rq[0] = mk(1, 32'h3, 32'h4, 0, OP_ADD, 0, 0, 0);
    n = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      step();
      if (last_g == 0) begin found = 1; n = i; end
    end
    chk("t4_wait_cycles", n, ML + 1);
    rq[0] = mk(1, 32'h5, 32'h6, 0, OP_ADD, 0, 0, 0);
    rq[1] = mk(1, 32'h7, 32'h8, 0, OP_ADD, 0, 0, 0);
    step();
    chk("t4_open_after", last_g, 1);

    // Randomized traffic; a stalled request is held stable
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++)
        if (!(rq[p].v && last_g != p)) rand_req(p);
      step();
    end
    rq[0].v = 1'b0; rq[1].v = 1'b0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
